// File: rtl/axi4_rab_pkg.sv
// Shared field widths and the packed-request width helper for the AXI4 address-channel buffer.
package axi4_rab_pkg;

   localparam int AXLEN_W    = 8;
   localparam int AXSIZE_W   = 3;
   localparam int AXBURST_W  = 2;
   localparam int AXLOCK_W   = 1;
   localparam int AXPROT_W   = 3;
   localparam int AXCACHE_W  = 4;
   localparam int AX_FIXED_W = AXLEN_W + AXSIZE_W + AXBURST_W + AXLOCK_W + AXPROT_W + AXCACHE_W;

   function automatic int ax_pack_width(input int addr_w, input int id_w, input int user_w);
      return addr_w + id_w + user_w + AX_FIXED_W;
   endfunction

endpackage

// File: rtl/axi4_ax_timer_fifo.sv
// In-order FIFO in which every entry carries a countdown loaded at push; the head may only
// leave once its own countdown has reached zero.
module axi4_ax_timer_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int LAT        = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = $clog2(LAT + 1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [TMR_W-1:0]      tmr_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  ready_r;
   logic                  push_s;
   logic                  pop_s;
   logic                  head_due_s;
   logic [CNT_W-1:0]      count_nxt_s;

   // Handshake decode and next occupancy; ready is the registered "not full" flag, so a full
   // FIFO never pushes even while it pops.
   always_comb begin
      head_due_s  = (count_r != CNT_W'(0)) && (tmr_r[rd_ptr_r] == TMR_W'(0));
      push_s      = in_valid && ready_r;
      pop_s       = head_due_s && out_ready;
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy, ready flag and per-entry timers; timers run from acceptance, not from
   // reaching the head, and saturate at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
         ready_r  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tmr_r[i] <= TMR_W'(0);
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (wr_ptr_r == PTR_W'(i))) begin
               tmr_r[i] <= TMR_W'(LAT);
            end else if (tmr_r[i] != TMR_W'(0)) begin
               tmr_r[i] <= tmr_r[i] - TMR_W'(1);
            end else begin
               tmr_r[i] <= TMR_W'(0);
            end
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
         ready_r <= (count_nxt_s != CNT_W'(DEPTH));
      end
   end

   // Payload storage; reset leaves it alone because out_data is masked while nothing is due.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   assign in_ready  = ready_r;
   assign out_valid = head_due_s;
   assign out_data  = head_due_s ? mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
   assign count     = count_r;

endmodule

// File: rtl/axi4_ax_timed_xlate_buffer.sv
// AXI4 AR/AW buffer with a fixed minimum latency and a programmable address offset.
// Define AXI4_AX_BUF_XLATE_EN to add cfg_offset_i to each accepted address.
module axi4_ax_timed_xlate_buffer
   import axi4_rab_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 4,
   parameter int DEPTH      = 4,
   parameter int LAT        = 5
) (
   input  logic                         axi4_aclk,
   input  logic                         axi4_arst,
   input  logic [ADDR_WIDTH-1:0]        cfg_offset_i,
   input  logic [ID_WIDTH-1:0]          s_axi4_axid,
   input  logic [ADDR_WIDTH-1:0]        s_axi4_axaddr,
   input  logic [AXLEN_W-1:0]           s_axi4_axlen,
   input  logic [AXSIZE_W-1:0]          s_axi4_axsize,
   input  logic [AXBURST_W-1:0]         s_axi4_axburst,
   input  logic [AXLOCK_W-1:0]          s_axi4_axlock,
   input  logic [AXPROT_W-1:0]          s_axi4_axprot,
   input  logic [AXCACHE_W-1:0]         s_axi4_axcache,
   input  logic [USER_WIDTH-1:0]        s_axi4_axuser,
   input  logic                         s_axi4_axvalid,
   output logic                         s_axi4_axready,
   output logic [ID_WIDTH-1:0]          m_axi4_axid,
   output logic [ADDR_WIDTH-1:0]        m_axi4_axaddr,
   output logic [AXLEN_W-1:0]           m_axi4_axlen,
   output logic [AXSIZE_W-1:0]          m_axi4_axsize,
   output logic [AXBURST_W-1:0]         m_axi4_axburst,
   output logic [AXLOCK_W-1:0]          m_axi4_axlock,
   output logic [AXPROT_W-1:0]          m_axi4_axprot,
   output logic [AXCACHE_W-1:0]         m_axi4_axcache,
   output logic [USER_WIDTH-1:0]        m_axi4_axuser,
   output logic                         m_axi4_axvalid,
   input  logic                         m_axi4_axready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

   localparam int PACK_W = ax_pack_width(ADDR_WIDTH, ID_WIDTH, USER_WIDTH);

   logic [ADDR_WIDTH-1:0] xlate_addr_s;
   logic [PACK_W-1:0]     in_pack_s;
   logic [PACK_W-1:0]     out_pack_s;

`ifdef AXI4_AX_BUF_XLATE_EN
   assign xlate_addr_s = s_axi4_axaddr + cfg_offset_i;
`else
   logic unused_offset_s;
   assign unused_offset_s = ^cfg_offset_i;
   assign xlate_addr_s    = s_axi4_axaddr;
`endif

   assign in_pack_s = {s_axi4_axid, xlate_addr_s, s_axi4_axlen, s_axi4_axsize, s_axi4_axburst,
                       s_axi4_axlock, s_axi4_axprot, s_axi4_axcache, s_axi4_axuser};

   axi4_ax_timer_fifo #(
      .DATA_WIDTH (PACK_W),
      .DEPTH      (DEPTH),
      .LAT        (LAT)
   ) u_fifo (
      .clk       (axi4_aclk),
      .rst       (axi4_arst),
      .in_data   (in_pack_s),
      .in_valid  (s_axi4_axvalid),
      .in_ready  (s_axi4_axready),
      .out_data  (out_pack_s),
      .out_valid (m_axi4_axvalid),
      .out_ready (m_axi4_axready),
      .count     (occupancy_o)
   );

   assign {m_axi4_axid, m_axi4_axaddr, m_axi4_axlen, m_axi4_axsize, m_axi4_axburst,
           m_axi4_axlock, m_axi4_axprot, m_axi4_axcache, m_axi4_axuser} = out_pack_s;

endmodule

// File: tb/tb_axi4_ax_timed_xlate_buffer.sv
// Self-checking bench: randomized requests against a queue model that tracks acceptance times.
module tb_axi4_ax_timed_xlate_buffer;

   localparam int DEPTH = 4;
   localparam int LAT   = 5;
`ifdef AXI4_AX_BUF_XLATE_EN
   localparam bit XL = 1'b1;
`else
   localparam bit XL = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [2:0]  prot;
      logic [3:0]  cache;
      logic [3:0]  user;
   } beat_t;

   typedef struct {
      beat_t b;
      int    t;
   } ent_t;

   logic        clk = 1'b0;
   logic        arst;
   logic [31:0] cfg_off;
   beat_t       s_req;
   logic        s_valid;
   logic        s_ready;
   logic        m_valid;
   logic        m_ready;
   logic [2:0]  occ;
   beat_t       m_beat;

   ent_t q[$];
   int   cyc = 0;
   bit   exp_ready = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   axi4_ax_timed_xlate_buffer #(
      .ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(4), .DEPTH(DEPTH), .LAT(LAT)
   ) dut (
      .axi4_aclk(clk), .axi4_arst(arst), .cfg_offset_i(cfg_off),
      .s_axi4_axid(s_req.id), .s_axi4_axaddr(s_req.addr), .s_axi4_axlen(s_req.len),
      .s_axi4_axsize(s_req.size), .s_axi4_axburst(s_req.burst), .s_axi4_axlock(s_req.lock),
      .s_axi4_axprot(s_req.prot), .s_axi4_axcache(s_req.cache), .s_axi4_axuser(s_req.user),
      .s_axi4_axvalid(s_valid), .s_axi4_axready(s_ready),
      .m_axi4_axid(m_beat.id), .m_axi4_axaddr(m_beat.addr), .m_axi4_axlen(m_beat.len),
      .m_axi4_axsize(m_beat.size), .m_axi4_axburst(m_beat.burst), .m_axi4_axlock(m_beat.lock),
      .m_axi4_axprot(m_beat.prot), .m_axi4_axcache(m_beat.cache), .m_axi4_axuser(m_beat.user),
      .m_axi4_axvalid(m_valid), .m_axi4_axready(m_ready), .occupancy_o(occ)
   );

   function automatic beat_t rand_beat();
      beat_t b;
      b = {$urandom(), $urandom(), $urandom()};
      return b;
   endfunction

   function automatic logic [31:0] xl(input logic [31:0] a, input logic [31:0] o);
      return a + (XL ? o : 32'd0);
   endfunction

   // Head of the model is visible once LAT edges have passed since its acceptance.
   function automatic bit exp_mvalid();
      return (q.size() > 0) && ((cyc - q[0].t) >= LAT);
   endfunction

   // One clock edge: advance the reference model from the inputs presented at that edge.
   task automatic tick();
      bit push;
      bit pop;
      ent_t e;
      push = s_valid && exp_ready;
      pop  = exp_mvalid() && m_ready;
      @(posedge clk);
      cyc++;
      if (arst) begin
         q.delete();
         exp_ready = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            e.b      = s_req;
            e.b.addr = xl(s_req.addr, cfg_off);
            e.t      = cyc;
            q.push_back(e);
         end
         exp_ready = (q.size() != DEPTH);
      end
      #1;
   endtask

   task automatic test_reset();
      arst = 1'b1; s_valid = 1'b1; m_ready = 1'b1; cfg_off = 32'h0; s_req = rand_beat();
      repeat (3) tick();
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_sready: got %b want 0", s_ready); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid: got %b want 0", m_valid); end
      n_cmp++; if (occ !== 3'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occ); end
      n_cmp++; if (m_beat !== '0) begin n_bad++; $display("FAIL reset_fields: got %h want 0", m_beat); end
      arst = 1'b0; s_valid = 1'b0;
      tick();
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_sready: got %b want 1", s_ready); end
   endtask

   task automatic test_single();
      beat_t exp_b;
      cfg_off = 32'h0000_1000; m_ready = 1'b1;
      s_req = rand_beat(); s_req.addr = 32'h0000_2000; s_req.len = 8'd3; s_req.id = 4'd5;
      exp_b = s_req; exp_b.addr = XL ? 32'h0000_3000 : 32'h0000_2000;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         tick();
         n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: edge+%0d got %b want 0", i, m_valid); end
      end
      tick();
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", m_valid); end
      n_cmp++; if (m_beat !== exp_b) begin n_bad++; $display("FAIL single_fields: got %h want %h", m_beat, exp_b); end
      tick();
      n_cmp++; if (m_valid !== 1'b0 || occ !== 3'd0) begin n_bad++; $display("FAIL single_pop: got valid %b occ %0d want 0 0", m_valid, occ); end
   endtask

   task automatic test_fill();
      int budget;
      m_ready = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_req = rand_beat();
         tick();
      end
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL fill_sready: got %b want 0", s_ready); end
      n_cmp++; if (occ !== 3'd4) begin n_bad++; $display("FAIL fill_occ: got %0d want 4", occ); end
      s_req = rand_beat();
      repeat (2) tick();
      n_cmp++; if (occ !== 3'd4) begin n_bad++; $display("FAIL fill_held: got %0d want 4", occ); end
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL fill_head_valid: got %b want 1", m_valid); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      n_cmp++; if (s_ready !== 1'b1 || occ !== 3'd3) begin n_bad++; $display("FAIL fill_after_pop: got rdy %b occ %0d want 1 3", s_ready, occ); end
      tick();
      s_valid = 1'b0;
      n_cmp++; if (occ !== 3'd4) begin n_bad++; $display("FAIL fill_fifth: got %0d want 4", occ); end
      m_ready = 1'b1; budget = 40;
      while (q.size() > 0 && budget > 0) begin
         tick(); budget--;
         n_cmp++; if (m_valid !== exp_mvalid()) begin n_bad++; $display("FAIL fill_drain_valid: got %b want %b", m_valid, exp_mvalid()); end
         if (exp_mvalid()) begin
            n_cmp++; if (m_beat !== q[0].b) begin n_bad++; $display("FAIL fill_drain_fields: got %h want %h", m_beat, q[0].b); end
         end
      end
      n_cmp++; if (occ !== 3'd0) begin n_bad++; $display("FAIL fill_drain_done: got %0d want 0", occ); end
   endtask

   task automatic test_stream();
      int n_acc = 0;
      int n_pop = 0;
      int k = -1;
      int first_v = -1;
      int budget = 200;
      bit acc;
      m_ready = 1'b1; s_valid = 1'b1; s_req = rand_beat();
      while ((n_acc < 16 || q.size() > 0) && budget > 0) begin
         acc = s_valid && exp_ready;
         if (m_valid && m_ready) n_pop++;
         tick(); budget--;
         if (acc) begin
            if (k < 0) k = cyc;
            n_acc++; s_req = rand_beat();
            if (n_acc == 16) s_valid = 1'b0;
         end
         if (first_v < 0 && m_valid === 1'b1) first_v = cyc;
         n_cmp++; if (m_valid !== exp_mvalid()) begin n_bad++; $display("FAIL stream_valid: cyc %0d got %b want %b", cyc, m_valid, exp_mvalid()); end
         n_cmp++; if (occ !== 3'(q.size())) begin n_bad++; $display("FAIL stream_occ: got %0d want %0d", occ, q.size()); end
         if (exp_mvalid()) begin
            n_cmp++; if (m_beat !== q[0].b) begin n_bad++; $display("FAIL stream_fields: got %h want %h", m_beat, q[0].b); end
         end
      end
      n_cmp++; if (first_v != k + LAT) begin n_bad++; $display("FAIL stream_first_valid: got cyc %0d want %0d", first_v, k + LAT); end
      n_cmp++; if (n_pop != 16) begin n_bad++; $display("FAIL stream_pops: got %0d want 16", n_pop); end
   endtask

   task automatic test_wrap();
      logic [31:0] want;
      cfg_off = 32'h0000_1000; m_ready = 1'b0;
      s_req = rand_beat(); s_req.addr = 32'hFFFF_F800; s_valid = 1'b1;
      want = XL ? 32'h0000_0800 : 32'hFFFF_F800;
      tick();
      s_valid = 1'b0;
      repeat (LAT) tick();
      n_cmp++; if (m_valid !== 1'b1 || m_beat.addr !== want) begin n_bad++; $display("FAIL wrap_addr: got v%b %h want v1 %h", m_valid, m_beat.addr, want); end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic test_stall();
      beat_t want;
      m_ready = 1'b0; cfg_off = $urandom(); s_req = rand_beat(); s_valid = 1'b1;
      want = s_req; want.addr = xl(s_req.addr, cfg_off);
      tick();
      s_valid = 1'b0;
      repeat (LAT) tick();
      for (int i = 0; i < 3; i++) begin
         cfg_off = $urandom();
         tick();
         n_cmp++; if (m_valid !== 1'b1 || m_beat !== want) begin n_bad++; $display("FAIL stall_hold: cyc %0d got v%b %h want v1 %h", i, m_valid, m_beat, want); end
      end
      m_ready = 1'b1;
      tick();
      n_cmp++; if (m_valid !== 1'b0 || occ !== 3'd0) begin n_bad++; $display("FAIL stall_single_pop: got v%b occ %0d want 0 0", m_valid, occ); end
   endtask

   task automatic test_mid_reset();
      m_ready = 1'b0; s_valid = 1'b1;
      repeat (2) begin s_req = rand_beat(); tick(); end
      s_valid = 1'b0;
      repeat (4) tick();
      arst = 1'b1;
      tick();
      arst = 1'b0;
      n_cmp++; if (m_valid !== 1'b0 || occ !== 3'd0) begin n_bad++; $display("FAIL midrst_clear: got v%b occ %0d want 0 0", m_valid, occ); end
      tick();
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_sready: got %b want 1", s_ready); end
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: cyc %0d got %b want 0", i, m_valid); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         s_valid = ($urandom_range(9) < 7);
         m_ready = ($urandom_range(9) < 6);
         s_req   = rand_beat();
         if ($urandom_range(15) == 0) cfg_off = $urandom();
         arst    = ($urandom_range(127) == 0);
         tick();
         n_cmp++; if (m_valid !== exp_mvalid()) begin n_bad++; $display("FAIL rand_valid: cyc %0d got %b want %b", cyc, m_valid, exp_mvalid()); end
         n_cmp++; if (s_ready !== exp_ready) begin n_bad++; $display("FAIL rand_sready: cyc %0d got %b want %b", cyc, s_ready, exp_ready); end
         n_cmp++; if (occ !== 3'(q.size())) begin n_bad++; $display("FAIL rand_occ: cyc %0d got %0d want %0d", cyc, occ, q.size()); end
         if (exp_mvalid()) begin
            n_cmp++; if (m_beat !== q[0].b) begin n_bad++; $display("FAIL rand_fields: cyc %0d got %h want %h", cyc, m_beat, q[0].b); end
         end
      end
      arst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_wrap();
      test_stall();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
